// File: rtl/mips_mem_pkg.sv
// Shared types for the data-memory arbiter: word/address types, arbiter
// state encoding and requester identifiers.
package mips_mem_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_MEM_AW = 8;

   typedef logic [DEF_DATA_W-1:0] word_t;
   typedef logic [DEF_ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {
      IDLE,
      CPU_BUSY,
      DBG_BUSY
   } arb_state_e;

   typedef enum logic {
      REQ_CPU,
      REQ_DBG
   } req_id_e;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker. Bit 0 is the CPU, bit 1 the debug port.
// Purely combinational; the caller owns the last-grant register.
module rr_arb2
   import mips_mem_pkg::*;
(
   input  logic [1:0] req,
   input  req_id_e    last,
   input  logic [1:0] mask,
   output logic [1:0] gnt,
   output req_id_e    gnt_id
);

   logic [1:0] eligible;

   always_comb begin
      eligible = req & ~mask;
      gnt      = 2'b00;
      gnt_id   = REQ_CPU;
      if (eligible == 2'b11) begin
         if (last == REQ_CPU) begin
            gnt    = 2'b10;
            gnt_id = REQ_DBG;
         end else begin
            gnt    = 2'b01;
         end
      end else if (eligible[1]) begin
         gnt    = 2'b10;
         gnt_id = REQ_DBG;
      end else if (eligible[0]) begin
         gnt    = 2'b01;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the core and the debug/loader
// port. Define DMEM_ARB_ALIGN_CHECK_EN to reject misaligned word accesses.
//
// state    | meaning
// IDLE     | no access in flight
// CPU_BUSY | CPU access issued last cycle; acked this cycle
// DBG_BUSY | debug access issued last cycle; acked this cycle
module dmem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int MEM_AW = DEF_MEM_AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              err
);

   arb_state_e        state;
   req_id_e           last_grant;
   req_id_e           gnt_id;
   logic [1:0]        gnt;
   logic [1:0]        busy_mask;
   logic              any_gnt;
   logic              win_we;
   logic              win_mis;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic              inflight_we;
   logic              inflight_mis;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dbg_rdata_q;
   logic              unused_addr_bits;

   assign busy_mask = {state == DBG_BUSY, state == CPU_BUSY};

   rr_arb2 u_rr_arb2 (
      .req    ({dbg_req, cpu_req}),
      .last   (last_grant),
      .mask   (busy_mask),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign any_gnt   = |gnt;
   assign win_we    = (gnt_id == REQ_DBG) ? dbg_we    : cpu_we;
   assign win_addr  = (gnt_id == REQ_DBG) ? dbg_addr  : cpu_addr;
   assign win_wdata = (gnt_id == REQ_DBG) ? dbg_wdata : cpu_wdata;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
   assign win_mis = any_gnt & (win_addr[1:0] != 2'b00);
`else
   assign win_mis = 1'b0;
`endif

   assign unused_addr_bits = ^{win_addr[ADDR_W-1:MEM_AW+2], win_addr[1:0]};

   assign mem_en    = any_gnt & ~win_mis;
   assign mem_we    = mem_en & win_we;
   assign mem_addr  = win_addr[MEM_AW+1:2];
   assign mem_wdata = win_wdata;

   // Memory read data arrives in the ack cycle, so it is forwarded directly
   // and captured into the hold register for the following cycles.
   always_comb begin
      cpu_rdata = cpu_rdata_q;
      dbg_rdata = dbg_rdata_q;
      if (cpu_ack)
         cpu_rdata = inflight_mis ? '0 : (inflight_we ? cpu_rdata_q : mem_rdata);
      if (dbg_ack)
         dbg_rdata = inflight_mis ? '0 : (inflight_we ? dbg_rdata_q : mem_rdata);
   end

   assign cpu_stall = cpu_req & ~cpu_ack;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         last_grant   <= REQ_DBG;
         cpu_ack      <= 1'b0;
         dbg_ack      <= 1'b0;
         err          <= 1'b0;
         inflight_we  <= 1'b0;
         inflight_mis <= 1'b0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         if (cpu_ack) cpu_rdata_q <= cpu_rdata;
         if (dbg_ack) dbg_rdata_q <= dbg_rdata;
         cpu_ack      <= gnt[0];
         dbg_ack      <= gnt[1];
         err          <= win_mis;
         inflight_we  <= win_we;
         inflight_mis <= win_mis;
         if (any_gnt) begin
            last_grant <= gnt_id;
            state      <= (gnt_id == REQ_DBG) ? DBG_BUSY : CPU_BUSY;
         end else begin
            state      <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed stimulus, a transaction-level reference
// model checked every cycle, and literal expectations for key scenarios.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_ack, cpu_stall;
   logic        dbg_req = 1'b0, dbg_we = 1'b0;
   logic [31:0] dbg_addr = '0, dbg_wdata = '0;
   logic [31:0] dbg_rdata;
   logic        dbg_ack;
   logic        mem_en, mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .err(err)
   );

   // Environment memory: synchronous, write-first.
   logic [31:0] mem [256];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            mem_rdata     <= mem_wdata;
         end else begin
            mem_rdata     <= mem[mem_addr];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a requester that was granted last cycle is acked now
   // and sits out this cycle's arbitration; ties go to whoever was not
   // granted most recently.
   logic [31:0] ref_mem [256];
   int          prev_g = 0;
   int          last_g = 2;
   logic        prev_we = 1'b0, prev_mis = 1'b0;
   logic [31:0] prev_val = '0, hold_c = '0, hold_d = '0;
   int          g;
   logic        ce, de, m_we, m_mis;
   logic [31:0] m_addr, m_wd, r;
   logic [7:0]  m_idx;

   always @(negedge clk) begin
      if (!reset) begin
         prev_g = 0; last_g = 2; prev_we = 1'b0; prev_mis = 1'b0;
         hold_c = '0; hold_d = '0;
      end else begin
         check("m_cpu_ack", {31'd0, cpu_ack}, {31'd0, prev_g == 1});
         check("m_dbg_ack", {31'd0, dbg_ack}, {31'd0, prev_g == 2});
         check("m_err", {31'd0, err}, {31'd0, prev_mis});
         if (prev_g != 0) begin
            r = prev_mis ? 32'd0 : (prev_we ? ((prev_g == 1) ? hold_c : hold_d) : prev_val);
            if (prev_g == 1) hold_c = r; else hold_d = r;
         end
         check("m_cpu_rdata", cpu_rdata, hold_c);
         check("m_dbg_rdata", dbg_rdata, hold_d);
         check("m_cpu_stall", {31'd0, cpu_stall}, {31'd0, cpu_req && prev_g != 1});
         ce = cpu_req && prev_g != 1;
         de = dbg_req && prev_g != 2;
         if (ce && de) g = (last_g == 1) ? 2 : 1;
         else if (ce)  g = 1;
         else if (de)  g = 2;
         else          g = 0;
         m_we   = (g == 2) ? dbg_we    : cpu_we;
         m_addr = (g == 2) ? dbg_addr  : cpu_addr;
         m_wd   = (g == 2) ? dbg_wdata : cpu_wdata;
         m_idx  = m_addr[9:2];
         m_mis  = 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
         m_mis  = (g != 0) && (m_addr[1:0] != 2'b00);
`endif
         check("m_mem_en", {31'd0, mem_en}, {31'd0, g != 0 && !m_mis});
         if (g != 0 && !m_mis) begin
            check("m_mem_we", {31'd0, mem_we}, {31'd0, m_we});
            check("m_mem_addr", {24'd0, mem_addr}, {24'd0, m_idx});
            if (m_we) check("m_mem_wdata", mem_wdata, m_wd);
         end
         if (g != 0) begin
            last_g   = g;
            prev_val = ref_mem[m_idx];
            if (m_we && !m_mis) ref_mem[m_idx] = m_wd;
         end
         prev_g   = g;
         prev_we  = m_we;
         prev_mis = m_mis;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   int acks;

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 32'(i * 40);
         ref_mem[i] = 32'(i * 40);
      end
      tick();
      samp();
      check("reset cpu_ack", {31'd0, cpu_ack}, 32'd0);
      check("reset err", {31'd0, err}, 32'd0);
      check("reset cpu_rdata", cpu_rdata, 32'd0);
      tick();
      reset = 1'b1;

      // 1: single CPU load of word 1
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd4;
      samp();
      check("t1 mem_en", {31'd0, mem_en}, 32'd1);
      check("t1 mem_addr", {24'd0, mem_addr}, 32'd1);
      check("t1 stall issue", {31'd0, cpu_stall}, 32'd1);
      tick();
      cpu_req = 1'b0;
      samp();
      check("t1 cpu_ack", {31'd0, cpu_ack}, 32'd1);
      check("t1 cpu_rdata", cpu_rdata, 32'd40);
      check("t1 stall ack", {31'd0, cpu_stall}, 32'd0);
      tick();

      // 2: simultaneous requests after reset interleave CPU, DBG, CPU
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd8;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd12;
      samp();
      check("t2 first grant", {24'd0, mem_addr}, 32'd2);
      tick();
      samp();
      check("t2 cpu_ack", {31'd0, cpu_ack}, 32'd1);
      check("t2 cpu_rdata", cpu_rdata, 32'd80);
      check("t2 dbg issue", {24'd0, mem_addr}, 32'd3);
      tick();
      samp();
      check("t2 dbg_ack", {31'd0, dbg_ack}, 32'd1);
      check("t2 dbg_rdata", dbg_rdata, 32'd120);
      check("t2 cpu_ack off", {31'd0, cpu_ack}, 32'd0);
      tick();
      samp();
      check("t2 cpu_ack again", {31'd0, cpu_ack}, 32'd1);
      tick();
      cpu_req = 1'b0; dbg_req = 1'b0;
      tick();

      // 3: debug store followed by CPU load of the same word
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'd8; dbg_wdata = 32'h2A;
      samp();
      check("t3 mem_we", {31'd0, mem_we}, 32'd1);
      tick();
      dbg_req = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd8;
      samp();
      check("t3 dbg_ack", {31'd0, dbg_ack}, 32'd1);
      check("t3 cpu issue", {31'd0, mem_en}, 32'd1);
      tick();
      cpu_req = 1'b0;
      samp();
      check("t3 cpu_rdata", cpu_rdata, 32'h2A);
      tick();

      // 4: lone CPU request held -> one access every other cycle
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd0;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         samp();
         check("t4 mem_en", {31'd0, mem_en}, (i % 2 == 0) ? 32'd1 : 32'd0);
         if (cpu_ack) acks++;
         tick();
      end
      cpu_req = 1'b0;
      check("t4 ack count", 32'(acks), 32'd3);
      tick();

      // 5: reset while the CPU access is in flight
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd4;
      samp();
      tick();
      reset = 1'b0;
      samp();
      check("t5 ack aborted", {31'd0, cpu_ack}, 32'd0);
      tick();
      reset = 1'b1;
      samp();
      check("t5 reissue", {31'd0, mem_en}, 32'd1);
      tick();
      cpu_req = 1'b0;
      samp();
      check("t5 cpu_ack", {31'd0, cpu_ack}, 32'd1);
      check("t5 cpu_rdata", cpu_rdata, 32'd40);
      tick();

      // 6: misaligned debug load
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd6;
      samp();
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      check("t6 no mem_en", {31'd0, mem_en}, 32'd0);
`else
      check("t6 mem_addr", {24'd0, mem_addr}, 32'd1);
`endif
      tick();
      dbg_req = 1'b0;
      samp();
      check("t6 dbg_ack", {31'd0, dbg_ack}, 32'd1);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      check("t6 dbg_rdata", dbg_rdata, 32'd0);
      check("t6 err", {31'd0, err}, 32'd1);
`else
      check("t6 dbg_rdata", dbg_rdata, 32'd40);
      check("t6 err", {31'd0, err}, 32'd0);
`endif
      tick();

      // 7: address truncation to the top word index
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hFFFF_FFFC; cpu_wdata = 32'hDEAD_BEEF;
      samp();
      check("t7 store idx", {24'd0, mem_addr}, 32'd255);
      tick();
      cpu_req = 1'b0;
      tick();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_03FC;
      samp();
      check("t7 load idx", {24'd0, mem_addr}, 32'd255);
      tick();
      cpu_req = 1'b0;
      samp();
      check("t7 cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
